add_sub_unit: RTL

Parametrised add/subtract functional unit for the Tomasulo-style datapath, fed by the reservation stations and retiring onto the common data bus (CDB). Instructions are accepted through a valid/ready issue handshake into a small input queue, executed one at a time with a configurable multi-cycle latency, and held on the output until the CDB arbiter grants the broadcast. Destination register and reservation-station label travel with each operation.

---
 rtl/add_sub_unit.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/add_sub_unit.sv
// add_sub_unit: queued multi-cycle add/subtract unit that retires results onto the CDB.
// Define ADD_SUB_UNIT_FLAGS_EN to add the registered Carry/Ovf flag outputs.
module add_sub_unit #(
  parameter int unsigned WIDTH = 9,
  parameter int unsigned TAG_W = 3,
  parameter int unsigned LAT   = 3,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             RUN,
  output logic             Ready,
  input  logic [2:0]       OpCode,
  input  logic [WIDTH-1:0] RegY,
  input  logic [WIDTH-1:0] RegZ,
  input  logic [TAG_W-1:0] XAddSub,
  input  logic [TAG_W-1:0] LabelAddSub,
  input  logic             CdbGrant,
  output logic             Done,
  output logic [WIDTH-1:0] Result,
  output logic [TAG_W-1:0] EnderecoSaida,
  output logic [TAG_W-1:0] Label
`ifdef ADD_SUB_UNIT_FLAGS_EN
  ,
  output logic             Carry,
  output logic             Ovf
`endif
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned LAT_W = $clog2(LAT + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, HOLD = 2'd2} state_t;

  state_t           state, state_nx;

  logic             q_sub [DEPTH];
  logic [WIDTH-1:0] q_y   [DEPTH];
  logic [WIDTH-1:0] q_z   [DEPTH];
  logic [TAG_W-1:0] q_x   [DEPTH];
  logic [TAG_W-1:0] q_lbl [DEPTH];
  logic [PTR_W-1:0] head, tail;
  logic [CNT_W-1:0] count;

  logic [LAT_W-1:0] cnt;
  logic             exec_sub;
  logic [WIDTH-1:0] exec_y, exec_z;
  logic [TAG_W-1:0] exec_x, exec_lbl;

  logic             empty, legal, push, pop, wr_out, out_free, last;
  logic [WIDTH-1:0] res_c;

  assign Ready    = count < CNT_W'(DEPTH);
  assign empty    = count == '0;
  assign legal    = (OpCode == 3'b000) || (OpCode == 3'b001);
  assign push     = RUN && Ready && legal;
  assign out_free = !Done || CdbGrant;
  assign last     = cnt == LAT_W'(1);

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Queue payload storage; only legal ops are stored, so the SUB bit is enough.
  always_ff @(posedge clk) begin
    if (push) begin
      q_sub[tail] <= OpCode[0];
      q_y[tail]   <= RegY;
      q_z[tail]   <= RegZ;
      q_x[tail]   <= XAddSub;
      q_lbl[tail] <= LabelAddSub;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= ptr_inc(tail);
      if (pop)  head <= ptr_inc(head);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (!empty) state_nx = BUSY;
      BUSY: begin
        if (last) begin
          if (out_free) state_nx = empty ? IDLE : BUSY;
          else          state_nx = HOLD;
        end
      end
      HOLD: if (out_free) state_nx = empty ? IDLE : BUSY;
      default: state_nx = IDLE;
    endcase
  end

  // Retiring an op frees the execute register, so the next head may load at the same edge.
  always_comb begin
    pop    = 1'b0;
    wr_out = 1'b0;
    case (state)
      IDLE: pop = !empty;
      BUSY: begin
        if (last && out_free) begin
          wr_out = 1'b1;
          pop    = !empty;
        end
      end
      HOLD: begin
        if (out_free) begin
          wr_out = 1'b1;
          pop    = !empty;
        end
      end
      default: ;
    endcase
  end

`ifdef ADD_SUB_UNIT_FLAGS_EN
  logic [WIDTH:0] wide_c;
  logic           carry_c, ovf_c;

  assign wide_c  = exec_sub ? ({1'b0, exec_y} - {1'b0, exec_z})
                            : ({1'b0, exec_y} + {1'b0, exec_z});
  assign res_c   = wide_c[WIDTH-1:0];
  assign carry_c = wide_c[WIDTH];
  assign ovf_c   = (exec_sub ? (exec_y[WIDTH-1] != exec_z[WIDTH-1])
                             : (exec_y[WIDTH-1] == exec_z[WIDTH-1]))
                   && (res_c[WIDTH-1] != exec_y[WIDTH-1]);
`else
  assign res_c = exec_sub ? (exec_y - exec_z) : (exec_y + exec_z);
`endif

  // Execute register, latency counter and the CDB-facing output register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt           <= '0;
      exec_sub      <= 1'b0;
      exec_y        <= '0;
      exec_z        <= '0;
      exec_x        <= '0;
      exec_lbl      <= '0;
      Done          <= 1'b0;
      Result        <= '0;
      EnderecoSaida <= '0;
      Label         <= '0;
`ifdef ADD_SUB_UNIT_FLAGS_EN
      Carry         <= 1'b0;
      Ovf           <= 1'b0;
`endif
    end else begin
      if (pop) begin
        cnt      <= LAT_W'(LAT);
        exec_sub <= q_sub[head];
        exec_y   <= q_y[head];
        exec_z   <= q_z[head];
        exec_x   <= q_x[head];
        exec_lbl <= q_lbl[head];
      end else if (wr_out) begin
        cnt <= '0;
      end else if (state == BUSY && !last) begin
        cnt <= cnt - LAT_W'(1);
      end

      if (wr_out) begin
        Done          <= 1'b1;
        Result        <= res_c;
        EnderecoSaida <= exec_x;
        Label         <= exec_lbl;
`ifdef ADD_SUB_UNIT_FLAGS_EN
        Carry         <= carry_c;
        Ovf           <= ovf_c;
`endif
      end else if (CdbGrant) begin
        Done <= 1'b0;
      end
    end
  end

endmodule
